arp_engine: RTL and testbench



---
 rtl/arp_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_arp_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_engine.sv
// ARP endpoint: parses RX frames for requests aimed at LOCAL_IP, streams the
// reply (or a gratuitous announcement) out through a registered valid/ready byte port.
module arp_engine #(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_12_34_56_78_9A,
  parameter logic [31:0] LOCAL_IP     = {8'd10, 8'd10, 8'd10, 8'd100},
  parameter bit          PAD_MIN      = 1'b1,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  input  logic       grat_req,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int unsigned IW = 6;
  localparam logic [IW-1:0] LAST_IDX = PAD_MIN ? 6'd59 : 6'd41;

  typedef enum logic [1:0] {S_IDLE, S_REPLY, S_GRAT} state_e;

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    case (i)
      3'd0:    mac_byte = m[47:40];
      3'd1:    mac_byte = m[39:32];
      3'd2:    mac_byte = m[31:24];
      3'd3:    mac_byte = m[23:16];
      3'd4:    mac_byte = m[15:8];
      3'd5:    mac_byte = m[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] i);
    case (i)
      2'd0:    ip_byte = a[31:24];
      2'd1:    ip_byte = a[23:16];
      2'd2:    ip_byte = a[15:8];
      default: ip_byte = a[7:0];
    endcase
  endfunction

  // Ethertype + fixed ARP header (bytes 12-21) of a request
  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    case (i)
      4'd0:    hdr_byte = 8'h08;
      4'd1:    hdr_byte = 8'h06;
      4'd3:    hdr_byte = 8'h01;
      4'd4:    hdr_byte = 8'h08;
      4'd6:    hdr_byte = 8'h06;
      4'd7:    hdr_byte = 8'h04;
      4'd9:    hdr_byte = 8'h01;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic grat, input logic [IW-1:0] i,
                                            input logic [47:0] dmac, input logic [31:0] dip);
    logic [47:0] dst;
    logic [47:0] tha;
    logic [31:0] tpa;
    dst = grat ? 48'hFFFF_FFFF_FFFF : dmac;
    tha = grat ? 48'h0 : dmac;
    tpa = grat ? LOCAL_IP : dip;
    frame_byte = 8'h00;
    if (i < 6'd6)       frame_byte = mac_byte(dst, 3'(i));
    else if (i < 6'd12) frame_byte = mac_byte(LOCAL_MAC, 3'(i - 6'd6));
    else if (i < 6'd22) frame_byte = (i == 6'd21 && !grat) ? 8'h02 : hdr_byte(4'(i - 6'd12));
    else if (i < 6'd28) frame_byte = mac_byte(LOCAL_MAC, 3'(i - 6'd22));
    else if (i < 6'd32) frame_byte = ip_byte(LOCAL_IP, 2'(i - 6'd28));
    else if (i < 6'd38) frame_byte = mac_byte(tha, 3'(i - 6'd32));
    else if (i < 6'd42) frame_byte = ip_byte(tpa, 2'(i - 6'd38));
  endfunction

  state_e          state_q, state_d;
  logic [IW-1:0]   rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic            uc_q, uc_d, bc_q, bc_d, match_q, match_d;
  logic            uc_n, bc_n, match_n, req_v, hs;
  logic [47:0]     sha_q, sha_d, req_mac_q, req_mac_d;
  logic [31:0]     spa_q, spa_d, req_ip_q, req_ip_d;
  logic [7:0]      tx_data_q, tx_data_d, drop_cnt_q, drop_cnt_d;
  logic            tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic            grat_pending_q, grat_pending_d, busy_q, busy_d;

  // RX parser: unicast/broadcast dst flags plus header/TPA match, restarted at byte 0
  always_comb begin
    uc_n    = (rx_idx_q == '0) ? 1'b1 : uc_q;
    bc_n    = (rx_idx_q == '0) ? ACCEPT_BCAST : bc_q;
    match_n = (rx_idx_q == '0) ? 1'b1 : match_q;
    if (rx_idx_q < 6'd6) begin
      uc_n = uc_n & (rx_data == mac_byte(LOCAL_MAC, 3'(rx_idx_q)));
      bc_n = bc_n & (rx_data == 8'hFF);
    end
    if (rx_idx_q >= 6'd12 && rx_idx_q < 6'd22)
      match_n = match_n & (rx_data == hdr_byte(4'(rx_idx_q - 6'd12)));
    if (rx_idx_q >= 6'd38 && rx_idx_q < 6'd42)
      match_n = match_n & (rx_data == ip_byte(LOCAL_IP, 2'(rx_idx_q - 6'd38)));
    req_v = rx_valid & rx_last & (uc_n | bc_n) & match_n & (rx_idx_q >= 6'd41);

    rx_idx_d = rx_idx_q;
    uc_d     = uc_q;
    bc_d     = bc_q;
    match_d  = match_q;
    sha_d    = sha_q;
    spa_d    = spa_q;
    if (rx_valid) begin
      uc_d    = uc_n;
      bc_d    = bc_n;
      match_d = match_n;
      if (rx_last)                  rx_idx_d = '0;
      else if (rx_idx_q != 6'd63)   rx_idx_d = rx_idx_q + 6'd1;
      if (rx_idx_q >= 6'd22 && rx_idx_q < 6'd28) sha_d = {sha_q[39:0], rx_data};
      if (rx_idx_q >= 6'd28 && rx_idx_q < 6'd32) spa_d = {spa_q[23:0], rx_data};
    end
  end

  assign hs = tx_valid_q & tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_v)               state_d = S_REPLY;
        else if (grat_pending_q) state_d = S_GRAT;
      end
      S_REPLY, S_GRAT: if (hs && tx_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // TX datapath: first byte loaded on frame start, next byte loaded on each handshake
  always_comb begin
    tx_idx_d       = tx_idx_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    tx_last_d      = tx_last_q;
    req_mac_d      = req_mac_q;
    req_ip_d       = req_ip_q;
    drop_cnt_d     = drop_cnt_q;
    grat_pending_d = grat_pending_q | grat_req;
    busy_d         = (state_d != S_IDLE);
    if (state_q == S_IDLE) begin
      if (req_v) begin
        req_mac_d  = sha_q;
        req_ip_d   = spa_q;
        tx_idx_d   = '0;
        tx_valid_d = 1'b1;
        tx_last_d  = 1'b0;
        tx_data_d  = frame_byte(1'b0, '0, sha_q, spa_q);
      end else if (grat_pending_q) begin
        grat_pending_d = grat_req;
        tx_idx_d       = '0;
        tx_valid_d     = 1'b1;
        tx_last_d      = 1'b0;
        tx_data_d      = frame_byte(1'b1, '0, req_mac_q, req_ip_q);
      end
    end else begin
      if (req_v && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      if (hs) begin
        if (tx_last_q) begin
          tx_idx_d   = '0;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          tx_data_d  = 8'h00;
        end else begin
          tx_idx_d  = tx_idx_q + 6'd1;
          tx_last_d = (tx_idx_d == LAST_IDX);
          tx_data_d = frame_byte(state_q == S_GRAT, tx_idx_d, req_mac_q, req_ip_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_idx_q       <= '0;
      uc_q           <= 1'b0;
      bc_q           <= 1'b0;
      match_q        <= 1'b0;
      sha_q          <= '0;
      spa_q          <= '0;
      tx_idx_q       <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      tx_last_q      <= 1'b0;
      req_mac_q      <= '0;
      req_ip_q       <= '0;
      drop_cnt_q     <= '0;
      grat_pending_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      rx_idx_q       <= rx_idx_d;
      uc_q           <= uc_d;
      bc_q           <= bc_d;
      match_q        <= match_d;
      sha_q          <= sha_d;
      spa_q          <= spa_d;
      tx_idx_q       <= tx_idx_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_last_q      <= tx_last_d;
      req_mac_q      <= req_mac_d;
      req_ip_q       <= req_ip_d;
      drop_cnt_q     <= drop_cnt_d;
      grat_pending_q <= grat_pending_d;
      busy_q         <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_arp_engine.sv
// Scoreboard bench for arp_engine: stimulus pushes expected TX bytes, a monitor
// pops and compares them on every tx handshake.
module tb_arp_engine;

  localparam logic [47:0] MY_MAC = 48'h02_12_34_56_78_9A;
  localparam logic [31:0] MY_IP  = 32'h0A0A0A64;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_last;
  logic       grat_req, busy;
  logic [7:0] drop_cnt;

  arp_engine dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .grat_req(grat_req), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_frame [0:63];
  logic [8:0] sb [$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_req(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [31:0] tpa, input logic [15:0] etype);
    logic [7:0] hdr [0:7];
    hdr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    for (int i = 0; i < 64; i++) rx_frame[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      rx_frame[i]      = dst[47-8*i -: 8];
      rx_frame[6+i]    = sha[47-8*i -: 8];
      rx_frame[22+i]   = sha[47-8*i -: 8];
    end
    rx_frame[12] = etype[15:8];
    rx_frame[13] = etype[7:0];
    for (int i = 0; i < 8; i++) rx_frame[14+i] = hdr[i];
    for (int i = 0; i < 4; i++) begin
      rx_frame[28+i] = spa[31-8*i -: 8];
      rx_frame[38+i] = tpa[31-8*i -: 8];
    end
  endtask

  // Expected 60-byte reply or gratuitous frame
  task automatic push_frame(input bit grat, input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0] f [0:59];
    logic [7:0] hdr [0:9];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    if (grat) hdr[9] = 8'h01;
    for (int i = 0; i < 60; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      f[i]    = grat ? 8'hFF : mac[47-8*i -: 8];
      f[6+i]  = MY_MAC[47-8*i -: 8];
      f[22+i] = MY_MAC[47-8*i -: 8];
      f[32+i] = grat ? 8'h00 : mac[47-8*i -: 8];
    end
    for (int i = 0; i < 10; i++) f[12+i] = hdr[i];
    for (int i = 0; i < 4; i++) begin
      f[28+i] = MY_IP[31-8*i -: 8];
      f[38+i] = grat ? MY_IP[31-8*i -: 8] : ip[31-8*i -: 8];
    end
    for (int i = 0; i < 60; i++) sb.push_back({(i == 59), f[i]});
  endtask

  task automatic send_frame(input int len, input bit grat_on_last);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_data  = rx_frame[i];
      rx_last  = (i == len - 1);
      grat_req = grat_on_last && (i == len - 1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
    grat_req = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int budget);
    int n = 0;
    while ((sb.size() != 0 || tx_valid) && n < budget) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b1;
    chk("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every handshaked byte, and check stability while stalled
  initial begin
    logic [8:0] exp;
    logic [7:0] held_d;
    logic       held_l;
    bit         prev_stall;
    prev_stall = 1'b0;
    held_d = 8'h00;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        if (prev_stall) begin
          chk("stall_hold_data", 32'(tx_data), 32'(held_d));
          chk("stall_hold_last", 32'(tx_last), 32'(held_l));
        end
        if (tx_ready) begin
          hs_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got %0h expected no byte at %0t", tx_data, $time);
          end else begin
            exp = sb.pop_front();
            chk("tx_byte", 32'({tx_last, tx_data}), 32'(exp));
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held_d = tx_data;
          held_l = tx_last;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int guard;
    logic [47:0] sha_a;
    logic [31:0] spa_a;
    sha_a = 48'h00_11_22_33_44_55;
    spa_a = 32'h0A0A0A01;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
    tx_ready = 1'b1; grat_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Broadcast request, sink always ready
    build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0806);
    push_frame(1'b0, sha_a, spa_a);
    base = hs_cnt;
    send_frame(60, 1'b0);
    chk("reply_latency", 32'(tx_valid), 32'd1);
    chk("reply_busy", 32'(busy), 32'd1);
    drain(1'b0, 200);
    chk("reply_len", 32'(hs_cnt - base), 32'd60);
    chk("idle_busy", 32'(busy), 32'd0);

    // Requests that must be ignored
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: build_req(BCAST, sha_a, spa_a, 32'h0A0A0A63, 16'h0806);
        1: build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0800);
        2: build_req(48'h02_12_34_56_78_9B, sha_a, spa_a, MY_IP, 16'h0806);
        default: build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0806);
      endcase
      send_frame((k == 3) ? 41 : 60, 1'b0);
      chk("ignored_tx_valid", 32'(tx_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ignored_busy", 32'(busy), 32'd0);
    end
    chk("ignored_drop_cnt", 32'(drop_cnt), 32'd0);

    // Unicast request in a minimal 42-byte frame
    build_req(MY_MAC, 48'hA0_B1_C2_D3_E4_F5, 32'h0A0A0A07, MY_IP, 16'h0806);
    push_frame(1'b0, 48'hA0_B1_C2_D3_E4_F5, 32'h0A0A0A07);
    base = hs_cnt;
    send_frame(42, 1'b0);
    chk("ucast_latency", 32'(tx_valid), 32'd1);
    drain(1'b0, 200);
    chk("ucast_len", 32'(hs_cnt - base), 32'd60);

    // Back-pressure: tx_ready toggling every cycle
    build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0806);
    push_frame(1'b0, sha_a, spa_a);
    base = hs_cnt;
    send_frame(60, 1'b0);
    drain(1'b1, 400);
    chk("stall_len", 32'(hs_cnt - base), 32'd60);

    // Second request during an active reply is dropped
    tx_ready = 1'b0;
    build_req(BCAST, 48'h66_55_44_33_22_11, 32'h0A0A0A02, MY_IP, 16'h0806);
    push_frame(1'b0, 48'h66_55_44_33_22_11, 32'h0A0A0A02);
    send_frame(42, 1'b0);
    build_req(BCAST, 48'hDE_AD_BE_EF_00_01, 32'h0A0A0A03, MY_IP, 16'h0806);
    send_frame(42, 1'b0);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    chk("drop_busy", 32'(busy), 32'd1);
    drain(1'b0, 200);

    // Drop counter saturation: 255 more drops
    tx_ready = 1'b0;
    build_req(BCAST, 48'h66_55_44_33_22_11, 32'h0A0A0A02, MY_IP, 16'h0806);
    push_frame(1'b0, 48'h66_55_44_33_22_11, 32'h0A0A0A02);
    send_frame(42, 1'b0);
    build_req(BCAST, 48'hDE_AD_BE_EF_00_01, 32'h0A0A0A03, MY_IP, 16'h0806);
    for (int k = 0; k < 254; k++) send_frame(42, 1'b0);
    chk("drop_reach_255", 32'(drop_cnt), 32'd255);
    send_frame(42, 1'b0);
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
    drain(1'b0, 200);

    // grat_req coincident with qualifying rx_last: reply first, then gratuitous
    build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0806);
    push_frame(1'b0, sha_a, spa_a);
    push_frame(1'b1, 48'h0, 32'h0);
    base = hs_cnt;
    send_frame(60, 1'b1);
    chk("both_latency", 32'(tx_valid), 32'd1);
    drain(1'b0, 400);
    chk("both_len", 32'(hs_cnt - base), 32'd120);

    // Standalone gratuitous ARP
    push_frame(1'b1, 48'h0, 32'h0);
    grat_req = 1'b1;
    @(posedge clk); #1;
    grat_req = 1'b0;
    chk("grat_pending_cycle", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("grat_latency", 32'(tx_valid), 32'd1);
    drain(1'b0, 200);

    // Reset while tx byte 20 is presented
    build_req(BCAST, sha_a, spa_a, MY_IP, 16'h0806);
    push_frame(1'b0, sha_a, spa_a);
    base = hs_cnt;
    send_frame(60, 1'b0);
    guard = 0;
    while (hs_cnt < base + 20 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rst_wait_byte20", 32'(hs_cnt - base), 32'd20);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_tx_last", 32'(tx_last), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    build_req(BCAST, 48'h0A_1B_2C_3D_4E_5F, 32'h0A0A0A09, MY_IP, 16'h0806);
    push_frame(1'b0, 48'h0A_1B_2C_3D_4E_5F, 32'h0A0A0A09);
    base = hs_cnt;
    send_frame(60, 1'b0);
    chk("postrst_latency", 32'(tx_valid), 32'd1);
    drain(1'b0, 200);
    chk("postrst_len", 32'(hs_cnt - base), 32'd60);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
